seg_scan_driver: RTL and testbench

- Downstream consumer of the operand/result formatting stages, which present six 7-segment digit patterns packed in a 42-bit `display` bus.
- Takes a frame snapshot of `display` and time-multiplexes it onto a common-segment 6-digit 7-segment display, one digit at a time.
- Inserts a blanking gap between digits to prevent ghosting.
- Emits a per-frame strobe for upstream pacing.

---
 rtl/seg_scan_driver.sv | 104 ++++++++++
 tb/tb_seg_scan_driver.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a common-segment multi-digit 7-segment display.
// One frame snapshot of `display`, blanking gap before each digit, per-frame strobe.
module seg_scan_driver #(
  parameter int DIGITS          = 6,
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [7*DIGITS-1:0]   display,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int   MAXT = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
  localparam int   CW   = $clog2(MAXT) + 1;
  localparam int   DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic POL  = (ACTIVE_LOW != 0);

  typedef enum logic {BLANK, SHOW} phase_t;

  phase_t                phase, phase_n;
  logic [DW-1:0]         d, d_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [7*DIGITS-1:0]   shadow, shadow_n;
  logic [6:0]            seg_n, seg_l;
  logic [DIGITS-1:0]     an_n, an_l;
  logic                  frame_done_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= BLANK;
      d          <= '0;
      cnt        <= '0;
      shadow     <= '0;
      seg        <= {7{POL}};
      an         <= {DIGITS{POL}};
      frame_done <= 1'b0;
    end else begin
      phase      <= phase_n;
      d          <= d_n;
      cnt        <= cnt_n;
      shadow     <= shadow_n;
      seg        <= seg_n;
      an         <= an_n;
      frame_done <= frame_done_n;
    end
  end

  // Outputs are decoded from the current state and registered, so they trail it by one cycle.
  always_comb begin
    phase_n      = phase;
    d_n          = d;
    cnt_n        = cnt;
    shadow_n     = shadow;
    seg_l        = '0;
    an_l         = '0;
    frame_done_n = 1'b0;

    if (!enable) begin
      phase_n = BLANK;
      d_n     = '0;
      cnt_n   = '0;
    end else begin
      if (phase == BLANK && d == '0 && cnt == '0)
        shadow_n = display;

      case (phase)
        BLANK: begin
          if (cnt == CW'(BLANK_TICKS - 1)) begin
            phase_n = SHOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        SHOW: begin
          seg_l    = shadow[7*int'(d) +: 7];
          an_l[d]  = 1'b1;
          if (cnt == CW'(TICKS_PER_DIGIT - 1)) begin
            phase_n = BLANK;
            cnt_n   = '0;
            if (d == DW'(DIGITS - 1)) begin
              d_n          = '0;
              frame_done_n = 1'b1;
            end else begin
              d_n = d + DW'(1);
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: phase_n = BLANK;
      endcase
    end

    seg_n = seg_l ^ {7{POL}};
    an_n  = an_l ^ {DIGITS{POL}};
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: one active-low and one active-high instance
// share clock/reset/enable; stimulus pushes per-cycle expectations, a monitor pops them.
module tb_seg_scan_driver;

  localparam int T = 4;
  localparam int B = 2;
  localparam int FRAME = 6 * (T + B);

  bit          clk;
  logic        reset;
  logic        enable;
  logic [41:0] disp_lo, disp_hi;
  logic [6:0]  seg_lo, seg_hi;
  logic [5:0]  an_lo, an_hi;
  logic        fd_lo, fd_hi;

  always #5 clk = ~clk;

  seg_scan_driver #(.DIGITS(6), .TICKS_PER_DIGIT(T), .BLANK_TICKS(B), .ACTIVE_LOW(1)) u_lo (
    .clk(clk), .reset(reset), .enable(enable), .display(disp_lo),
    .seg(seg_lo), .an(an_lo), .frame_done(fd_lo));

  seg_scan_driver #(.DIGITS(6), .TICKS_PER_DIGIT(T), .BLANK_TICKS(B), .ACTIVE_LOW(0)) u_hi (
    .clk(clk), .reset(reset), .enable(enable), .display(disp_hi),
    .seg(seg_hi), .an(an_hi), .frame_done(fd_hi));

  typedef struct {
    logic [6:0] seg_lo; logic [5:0] an_lo; logic fd_lo;
    logic [6:0] seg_hi; logic [5:0] an_hi; logic fd_hi;
    int         pos;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          passes = 0;
  int          pos    = 0;
  logic [41:0] snap_lo = '0, snap_hi = '0;

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] want, input int p);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s pos=%0d got=%h expected=%h t=%0t", name, p, got, want, $time);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("seg_lo", seg_lo, e.seg_lo, e.pos);
      chk("an_lo", {1'b0, an_lo}, {1'b0, e.an_lo}, e.pos);
      chk("fd_lo", {6'b0, fd_lo}, {6'b0, e.fd_lo}, e.pos);
      chk("seg_hi", seg_hi, e.seg_hi, e.pos);
      chk("an_hi", {1'b0, an_hi}, {1'b0, e.an_hi}, e.pos);
      chk("fd_hi", {6'b0, fd_hi}, {6'b0, e.fd_hi}, e.pos);
    end
  end

  // Output timeline position p within a frame: p%6 in {0,1} is blanking, else digit p/6 is lit.
  function automatic void model(input int p, input logic [41:0] s, input bit pol,
                                output logic [6:0] sg, output logic [5:0] a);
    sg = '0;
    a  = '0;
    if (p % 6 >= 2) begin
      sg = s[7*(p/6) +: 7];
      a  = 6'b000001 << (p / 6);
    end
    if (pol) begin
      sg = ~sg;
      a  = ~a;
    end
  endfunction

  task automatic step();
    exp_t e;
    if (reset || !enable) begin
      pos = 0;
      model(0, snap_lo, 1'b1, e.seg_lo, e.an_lo);
      model(0, snap_hi, 1'b0, e.seg_hi, e.an_hi);
      e.fd_lo = 1'b0;
      e.fd_hi = 1'b0;
      e.pos   = -1;
    end else begin
      if (pos == 0) begin
        snap_lo = disp_lo;
        snap_hi = disp_hi;
      end
      model(pos, snap_lo, 1'b1, e.seg_lo, e.an_lo);
      model(pos, snap_hi, 1'b0, e.seg_hi, e.an_hi);
      e.fd_lo = (pos == FRAME - 1);
      e.fd_hi = (pos == FRAME - 1);
      e.pos   = pos;
      pos     = (pos + 1) % FRAME;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_until(input int p);
    int guard = 0;
    while (pos != p && guard < 2 * FRAME) begin
      step();
      guard++;
    end
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    disp_lo = {14'h0, 7'b0000001, 7'b0110000, 7'b1101101, 7'b1111110};
    disp_hi = {35'h0, 7'b0110000};

    // Reset held three cycles; the last one also has enable high (reset wins).
    run(2);
    enable = 1'b1;
    run(1);
    reset = 1'b0;

    // Two full frames of basic scanning.
    run(2 * FRAME);

    // Tearing: new pattern arrives while digit 2 is lit.
    run_until(15);
    disp_lo = '1;
    run(FRAME - 15 + FRAME);

    // Enable drop while digit 3 is lit, new pattern while parked, then re-enable.
    run_until(21);
    enable  = 1'b0;
    disp_lo = {7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 7'h66};
    run(3);
    enable = 1'b1;
    run(FRAME + 4);

    // Reset while digit 4 is lit; after release first lit digit shows an all-zero pattern.
    run_until(27);
    reset   = 1'b1;
    disp_lo = '0;
    run(2);
    reset = 1'b0;
    run(FRAME + 4);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      $display("FAIL queue_drain got=%0d expected=0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
